// File: rtl/eq_pkg.sv
// Shared constants for the two-band FIR equaliser.
// Tap count, widths, fixed band coefficients and the gain shift.
package eq_pkg;
  localparam int NTAPS = 16;
  localparam int DW    = 8;
  localparam int BSUMW = 20;
  localparam int BPW   = 16;
  localparam int HPW   = 17;
  localparam int GAIN_UNITY_SHIFT = 2;

  localparam logic [7:0] BASS_COEF [NTAPS] = '{
    8'd1,  8'd2,  8'd4,  8'd7,
    8'd11, 8'd15, 8'd19, 8'd21,
    8'd21, 8'd19, 8'd15, 8'd11,
    8'd7,  8'd4,  8'd2,  8'd1
  };

  localparam logic signed [8:0] HIGH_COEF [NTAPS] = '{
    9'sd0,   -9'sd1,  -9'sd3,  -9'sd6,
    -9'sd10, -9'sd15, -9'sd20, 9'sd100,
    9'sd100, -9'sd20, -9'sd15, -9'sd10,
    -9'sd6,  -9'sd3,  -9'sd1,  9'sd0
  };
endpackage

// File: rtl/bass_gain_sat.sv
// Bass band gain: out = min((in * gain) >> 2, 2^20-1), registered.
// Ports: clk, reset, gain_b, in_bass, rdy_add_bass -> out_bass, rdy_ctrl_bass.
module bass_gain_sat
  import eq_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       gain_b,
  input  logic [BSUMW-1:0] in_bass,
  input  logic             rdy_add_bass,
  output logic [BSUMW-1:0] out_bass,
  output logic             rdy_ctrl_bass
);
  localparam int PW = BSUMW + 3;

  logic [PW-1:0]    prod;
  logic [PW-1:0]    scaled;
  logic [BSUMW-1:0] sat;

  assign prod   = PW'(in_bass) * PW'(gain_b);
  assign scaled = prod >> GAIN_UNITY_SHIFT;
  // Any bit above the output width means overflow.
  assign sat    = (|scaled[PW-1:BSUMW]) ? '1
                                        : scaled[BSUMW-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      out_bass      <= '0;
      rdy_ctrl_bass <= 1'b0;
    end else begin
      rdy_ctrl_bass <= rdy_add_bass;
      if (rdy_add_bass)
        out_bass <= sat;
    end
  end
endmodule

// File: rtl/eq_coeff_gain_stage.sv
// Equaliser multiply stage: per-tap bass/treble products and bass gain.
// Ports: data_in/rdy_shift -> bass_prod, high_prod, rdy_coe_*; in_bass -> out_bass.
module eq_coeff_gain_stage
  import eq_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NTAPS*DW-1:0]  data_in,
  input  logic                 rdy_shift,
  output logic [NTAPS*BPW-1:0] bass_prod,
  output logic                 rdy_coe_bass,
  output logic [NTAPS*HPW-1:0] high_prod,
  output logic                 rdy_coe_high,
  input  logic [2:0]           gain_b,
  input  logic [BSUMW-1:0]     in_bass,
  input  logic                 rdy_add_bass,
  output logic [BSUMW-1:0]     out_bass,
  output logic                 rdy_ctrl_bass
);
  logic [NTAPS*BPW-1:0] bass_nxt;
  logic [NTAPS*HPW-1:0] high_nxt;

  for (genvar k = 0; k < NTAPS; k++) begin : g_tap
    logic [DW-1:0]         d;
    logic signed [HPW-1:0] hp;
    assign d  = data_in[k*DW +: DW];
    assign bass_nxt[k*BPW +: BPW] =
      BPW'(d) * BPW'(BASS_COEF[k]);
    // Zero-extend the sample so it multiplies as signed.
    assign hp = HPW'($signed({1'b0, d}))
              * HPW'(HIGH_COEF[k]);
    assign high_nxt[k*HPW +: HPW] = hp;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bass_prod    <= '0;
      high_prod    <= '0;
      rdy_coe_bass <= 1'b0;
      rdy_coe_high <= 1'b0;
    end else begin
      rdy_coe_bass <= rdy_shift;
      rdy_coe_high <= rdy_shift;
      if (rdy_shift) begin
        bass_prod <= bass_nxt;
        high_prod <= high_nxt;
      end
    end
  end

  bass_gain_sat u_gain (
    .clk           (clk),
    .reset         (reset),
    .gain_b        (gain_b),
    .in_bass       (in_bass),
    .rdy_add_bass  (rdy_add_bass),
    .out_bass      (out_bass),
    .rdy_ctrl_bass (rdy_ctrl_bass)
  );
endmodule

// File: tb/tb_eq_coeff_gain_stage.sv
// Directed bench for eq_coeff_gain_stage.
// Inputs driven on negedge, outputs sampled on the following negedge.
module tb_eq_coeff_gain_stage;
  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] data_in;
  logic         rdy_shift;
  logic [255:0] bass_prod;
  logic         rdy_coe_bass;
  logic [271:0] high_prod;
  logic         rdy_coe_high;
  logic [2:0]   gain_b;
  logic [19:0]  in_bass;
  logic         rdy_add_bass;
  logic [19:0]  out_bass;
  logic         rdy_ctrl_bass;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  eq_coeff_gain_stage dut (
    .clk           (clk),
    .reset         (reset),
    .data_in       (data_in),
    .rdy_shift     (rdy_shift),
    .bass_prod     (bass_prod),
    .rdy_coe_bass  (rdy_coe_bass),
    .high_prod     (high_prod),
    .rdy_coe_high  (rdy_coe_high),
    .gain_b        (gain_b),
    .in_bass       (in_bass),
    .rdy_add_bass  (rdy_add_bass),
    .out_bass      (out_bass),
    .rdy_ctrl_bass (rdy_ctrl_bass)
  );

  task automatic test_reset;
    reset = 1'b1;
    data_in = '0; rdy_shift = 0;
    gain_b = 0; in_bass = 0; rdy_add_bass = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (bass_prod !== '0 || high_prod !== '0 ||
        out_bass !== '0 || rdy_coe_bass !== 0 ||
        rdy_coe_high !== 0 || rdy_ctrl_bass !== 0) begin
      errors++;
      $display("FAIL reset_state bass=%h high=%h out=%h rdy=%b%b%b want all 0",
               bass_prod, high_prod, out_bass,
               rdy_coe_bass, rdy_coe_high, rdy_ctrl_bass);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ones;
    data_in = {16{8'h01}};
    rdy_shift = 1;
    @(negedge clk);
    rdy_shift = 0;
    checks++;
    if (bass_prod[7*16 +: 16] !== 16'd21) begin
      errors++;
      $display("FAIL ones_bass7 got %0d want 21", bass_prod[7*16 +: 16]);
    end
    checks++;
    if (high_prod[7*17 +: 17] !== 17'd100) begin
      errors++;
      $display("FAIL ones_high7 got %h want 00064", high_prod[7*17 +: 17]);
    end
    checks++;
    if (high_prod[1*17 +: 17] !== 17'h1FFFF) begin
      errors++;
      $display("FAIL ones_high1 got %h want 1ffff", high_prod[1*17 +: 17]);
    end
    checks++;
    if (high_prod[0 +: 17] !== 17'h0) begin
      errors++;
      $display("FAIL ones_high0 got %h want 0", high_prod[0 +: 17]);
    end
    checks++;
    if (rdy_coe_bass !== 1 || rdy_coe_high !== 1) begin
      errors++;
      $display("FAIL ones_rdy_high got %b%b want 11", rdy_coe_bass, rdy_coe_high);
    end
    @(negedge clk);
    checks++;
    if (rdy_coe_bass !== 0 || rdy_coe_high !== 0) begin
      errors++;
      $display("FAIL ones_rdy_low got %b%b want 00", rdy_coe_bass, rdy_coe_high);
    end
  endtask

  task automatic test_max;
    data_in = {16{8'hFF}};
    rdy_shift = 1;
    @(negedge clk);
    rdy_shift = 0;
    checks++;
    if (bass_prod[7*16 +: 16] !== 16'd5355 ||
        bass_prod[0 +: 16] !== 16'd255) begin
      errors++;
      $display("FAIL max_bass got %0d,%0d want 5355,255",
               bass_prod[7*16 +: 16], bass_prod[0 +: 16]);
    end
    checks++;
    if (high_prod[6*17 +: 17] !== 17'h1EC14) begin
      errors++;
      $display("FAIL max_high6 got %h want 1ec14", high_prod[6*17 +: 17]);
    end
    checks++;
    if (high_prod[8*17 +: 17] !== 17'd25500) begin
      errors++;
      $display("FAIL max_high8 got %0d want 25500", high_prod[8*17 +: 17]);
    end
    @(negedge clk);
  endtask

  task automatic test_gain;
    logic [19:0] ins  [5] = '{20'd1000, 20'd1000, 20'd1000,
                              20'hFFFFF, 20'h80000};
    logic [2:0]  gs   [5] = '{3'd4, 3'd7, 3'd0, 3'd5, 3'd3};
    logic [19:0] exps [5] = '{20'd1000, 20'd1750, 20'd0,
                              20'hFFFFF, 20'h60000};
    for (int i = 0; i < 5; i++) begin
      in_bass = ins[i];
      gain_b = gs[i];
      rdy_add_bass = 1;
      @(negedge clk);
      rdy_add_bass = 0;
      in_bass = 20'h12345;
      gain_b = 3'd6;
      checks++;
      if (out_bass !== exps[i] || rdy_ctrl_bass !== 1) begin
        errors++;
        $display("FAIL gain_%0d got out=%h rdy=%b want out=%h rdy=1",
                 i, out_bass, rdy_ctrl_bass, exps[i]);
      end
      @(negedge clk);
      checks++;
      if (rdy_ctrl_bass !== 0 || out_bass !== exps[i]) begin
        errors++;
        $display("FAIL gain_hold_%0d got out=%h rdy=%b want out=%h rdy=0",
                 i, out_bass, rdy_ctrl_bass, exps[i]);
      end
    end
  endtask

  task automatic test_reset_priority;
    logic [127:0] d;
    data_in = {16{8'h01}};
    rdy_shift = 1;
    in_bass = 20'd1000; gain_b = 3'd4;
    rdy_add_bass = 1;
    reset = 1;
    @(negedge clk);
    rdy_shift = 0; rdy_add_bass = 0;
    reset = 0;
    checks++;
    if (bass_prod !== '0 || high_prod !== '0 ||
        out_bass !== '0 || rdy_coe_bass !== 0 ||
        rdy_coe_high !== 0 || rdy_ctrl_bass !== 0) begin
      errors++;
      $display("FAIL reset_priority out=%h rdy=%b%b%b want all 0",
               out_bass, rdy_coe_bass, rdy_coe_high, rdy_ctrl_bass);
    end
    @(negedge clk);
    checks++;
    if (rdy_coe_bass !== 0 || rdy_ctrl_bass !== 0) begin
      errors++;
      $display("FAIL reset_drop rdy=%b%b want 00", rdy_coe_bass, rdy_ctrl_bass);
    end
    for (int k = 0; k < 16; k++) d[k*8 +: 8] = 8'(k + 1);
    data_in = d;
    rdy_shift = 1;
    in_bass = 20'd400; gain_b = 3'd6;
    rdy_add_bass = 1;
    @(negedge clk);
    rdy_shift = 0; rdy_add_bass = 0;
    checks++;
    if (bass_prod[3*16 +: 16] !== 16'd28 ||
        high_prod[3*17 +: 17] !== 17'h1FFE8 || rdy_coe_high !== 1) begin
      errors++;
      $display("FAIL post_reset_coef got %0d,%h,%b want 28,1ffe8,1",
               bass_prod[3*16 +: 16], high_prod[3*17 +: 17], rdy_coe_high);
    end
    checks++;
    if (out_bass !== 20'd600 || rdy_ctrl_bass !== 1) begin
      errors++;
      $display("FAIL post_reset_gain got %0d,%b want 600,1",
               out_bass, rdy_ctrl_bass);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    data_in = {16{8'h02}};
    rdy_shift = 1;
    in_bass = 20'd100; gain_b = 3'd4;
    rdy_add_bass = 1;
    @(negedge clk);
    data_in = {16{8'h03}};
    gain_b = 3'd2;
    checks++;
    if (bass_prod[7*16 +: 16] !== 16'd42 || rdy_coe_bass !== 1 ||
        out_bass !== 20'd100 || rdy_ctrl_bass !== 1) begin
      errors++;
      $display("FAIL b2b_first got %0d,%b,%0d,%b want 42,1,100,1",
               bass_prod[7*16 +: 16], rdy_coe_bass, out_bass, rdy_ctrl_bass);
    end
    @(negedge clk);
    rdy_shift = 0; rdy_add_bass = 0;
    data_in = {16{8'h09}};
    checks++;
    if (bass_prod[7*16 +: 16] !== 16'd63 ||
        high_prod[7*17 +: 17] !== 17'd300 || rdy_coe_high !== 1 ||
        out_bass !== 20'd50 || rdy_ctrl_bass !== 1) begin
      errors++;
      $display("FAIL b2b_second got %0d,%0d,%b,%0d,%b want 63,300,1,50,1",
               bass_prod[7*16 +: 16], high_prod[7*17 +: 17],
               rdy_coe_high, out_bass, rdy_ctrl_bass);
    end
    @(negedge clk);
    checks++;
    if (rdy_coe_bass !== 0 || rdy_coe_high !== 0 || rdy_ctrl_bass !== 0 ||
        bass_prod[7*16 +: 16] !== 16'd63 ||
        high_prod[9*17 +: 17] !== 17'h1FFC4) begin
      errors++;
      $display("FAIL b2b_hold got rdy=%b%b%b b7=%0d h9=%h want 000,63,1ffc4",
               rdy_coe_bass, rdy_coe_high, rdy_ctrl_bass,
               bass_prod[7*16 +: 16], high_prod[9*17 +: 17]);
    end
  endtask

  initial begin
    test_reset();
    test_ones();
    test_max();
    test_gain();
    test_reset_priority();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/eq_coeff_gain_stage.md
Name: eq_coeff_gain_stage

Overview:
- Multiply stage of the two-band FIR equaliser, plus the bass gain control.
- Takes 16 taps of 8-bit unsigned audio from the shift register and multiplies every tap by a fixed bass (low-pass) coefficient and a fixed treble (high-pass) coefficient. Results go to the band adders.
- Also scales the summed bass band by a 3-bit user gain, with saturation, before the final adder.

Parameters:
- NTAPS, 16, number of FIR taps.
- DW, 8, sample width (unsigned).
- BSUMW, 20, width of the bass sum and the scaled bass output.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- data_in  in  128  16 samples × 8 bit; tap k in bits [8k+7:8k].
- rdy_shift  in  1  one-cycle strobe: data_in is valid.
- bass_prod  out  256  16 × 16-bit unsigned products; tap k in bits [16k+15:16k].
- rdy_coe_bass  out  1  bass products valid strobe.
- high_prod  out  272  16 × 17-bit two's-complement products; tap k in bits [17k+16:17k].
- rdy_coe_high  out  1  treble products valid strobe.
- gain_b  in  3  bass gain code, 0..7.
- in_bass  in  20  unsigned summed bass band.
- rdy_add_bass  in  1  in_bass valid strobe.
- out_bass  out  20  scaled bass band, unsigned.
- rdy_ctrl_bass  out  1  out_bass valid strobe.

Behaviour:
- Reset:
  - All product registers, out_bass and all rdy outputs are 0.
  - Reset has priority over any strobe in the same cycle.
  - A strobe arriving during reset is dropped.
- Bass coefficients, unsigned 8-bit, taps 0..15: 1,2,4,7,11,15,19,21,21,19,15,11,7,4,2,1.
- Treble coefficients, signed 9-bit, taps 0..15: 0,-1,-3,-6,-10,-15,-20,100,100,-20,-15,-10,-6,-3,-1,0.
- Bass product: bass_prod[k] = data_in[k] × cb[k], unsigned, exact in 16 bits.
- Treble product: high_prod[k] = {0,data_in[k]} × ch[k], signed, exact in 17 bits.
- Coefficient latency:
  - On a clk edge with rdy_shift=1, all 32 products are registered.
  - rdy_coe_bass and rdy_coe_high are 1 for exactly the following cycle, then 0.
  - Without rdy_shift, products hold their previous value.
- Bass gain: on a clk edge with rdy_add_bass=1:
  - out_bass <= min((in_bass × gain_b) >> 2, 2^20−1).
  - gain 4 = unity; gain 0 = mute; gain 7 = ×1.75.
  - Use a 23-bit intermediate product; truncate toward zero.
  - rdy_ctrl_bass pulses for 1 cycle, 1 cycle after rdy_add_bass.
  - gain_b is sampled in the same cycle as rdy_add_bass.
- Back-to-back strobes on consecutive cycles:
  - Each strobe is processed independently.
  - The matching rdy output stays high for consecutive cycles.
- The coefficient path and the gain path are independent and may strobe simultaneously.

Decomposition:
- Package eq_pkg holds:
  - NTAPS, DW, BSUMW;
  - the constant arrays BASS_COEF[16] (8-bit) and HIGH_COEF[16] (signed 9-bit);
  - a localparam GAIN_UNITY_SHIFT = 2.
- One natural sub-module: bass_gain_sat (multiply, shift, saturate, register the output, register the rdy).
- The tap multipliers are generate loops inside the top module.

Test Plan:
- All 16 samples = 1, pulse rdy_shift:
  - next cycle bass_prod[7] = 21 and high_prod[7] = 100;
  - high_prod[1] = 0x1FFFF (−1) and high_prod[0] = 0;
  - both rdy outputs high for exactly one cycle.
- All samples = 255, strobe:
  - bass_prod[7] = 5355, bass_prod[0] = 255;
  - high_prod[6] = 0x1EC14 (−5100) and high_prod[8] = 25500.
- in_bass = 1000, strobe with gain_b = 4, then 7, then 0:
  - out_bass = 1000, then 1750, then 0;
  - rdy_ctrl_bass pulses one cycle after each strobe.
- in_bass = 0xFFFFF with gain_b = 5 → out_bass = 0xFFFFF (saturated).
- in_bass = 0x80000 with gain_b = 3 → out_bass = 0x60000.
- Assert reset in the same cycle as rdy_shift and rdy_add_bass:
  - all outputs 0 and no rdy pulse;
  - after release, a new strobe works normally.
- Strobe rdy_shift on two consecutive cycles with different data:
  - products update on each edge;
  - rdy_coe outputs high for 2 cycles;
  - products hold afterwards.
